adc_uart_framer: RTL



---
 rtl/adc_uart_framer.sv | 226 ++++++++++++++++++++++
 1 files changed

// File: rtl/adc_uart_framer.sv
// Drains 16-bit samples from a non-show-ahead FIFO and sends them as framed bytes over a UART 8N1 line.
// Optional trailing checksum byte is compiled in with `define ADC_FRAMER_CHECKSUM_EN.
module adc_uart_framer #(
  parameter int          CLK_FREQ          = 50000000,
  parameter int          BAUD              = 115200,
  parameter int          SAMPLES_PER_FRAME = 4,
  parameter logic [7:0]  HEADER            = 8'hA5
) (
  input  logic        sysclk_50,
  input  logic        i_rest_n,
  input  logic        enable,
  input  logic        fifo_empty,
  input  logic [15:0] fifo_q,
  output logic        fifo_rdreq,
  output logic        uart_tx,
  output logic        busy,
  output logic        frame_done,
  output logic [15:0] frame_cnt
);
  // state   | meaning
  // IDLE    | waiting for enable and a non-empty FIFO
  // HDR     | launch the header byte
  // FETCH   | strobe the FIFO (stalls while empty)
  // WAIT_Q  | capture FIFO read data
  // SEND_HI | launch sample[15:8] once the line is free
  // SEND_LO | launch sample[7:0]; with r_tail set, wait for the final byte to finish
  // CKSUM   | launch checksum, then wait for it to finish
  // DONE    | one-cycle end-of-frame pulse
  localparam int               BAUD_DIV   = CLK_FREQ / BAUD;
  localparam int               CW         = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 1;
  localparam logic [CW-1:0]    BIT_RELOAD = CW'(BAUD_DIV - 1);
  localparam logic [7:0]       LAST_IDX   = 8'(SAMPLES_PER_FRAME - 1);

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [2:0] {
    IDLE, HDR, FETCH, WAIT_Q, SEND_HI, SEND_LO,
`ifdef ADC_FRAMER_CHECKSUM_EN
    CKSUM,
`endif
    DONE
  } frame_state_t;

  tx_state_t    r_tx_state, w_tx_state_nxt;
  logic [CW-1:0] r_baud_cnt, w_baud_nxt;
  logic [2:0]   r_bit_idx, w_bit_idx_nxt;
  logic [7:0]   r_shift, w_shift_nxt;
  logic         r_line, w_line_nxt;
  logic         w_bit_end, w_tx_done, w_tx_ready, w_tx_start;
  logic [7:0]   w_tx_byte;

  frame_state_t r_state, w_state_nxt;
  logic [7:0]   r_idx, w_idx_nxt;
  logic [15:0]  r_sample, w_sample_nxt;
  logic         r_tail, w_tail_nxt;
  logic [15:0]  r_frame_cnt, w_cnt_nxt;
`ifdef ADC_FRAMER_CHECKSUM_EN
  logic [7:0]   r_cksum, w_cksum_nxt;
`endif

  assign w_bit_end  = (r_baud_cnt == '0);
  assign w_tx_done  = (r_tx_state == TX_STOP) && w_bit_end;
  // Launching in the tx_done cycle keeps consecutive bytes gap-free.
  assign w_tx_ready = (r_tx_state == TX_IDLE) || w_tx_done;

  always_comb begin
    w_tx_state_nxt = r_tx_state;
    w_baud_nxt     = w_bit_end ? r_baud_cnt : r_baud_cnt - CW'(1);
    w_bit_idx_nxt  = r_bit_idx;
    w_shift_nxt    = r_shift;
    case (r_tx_state)
      TX_IDLE: if (w_tx_start) begin
        w_tx_state_nxt = TX_START;
        w_baud_nxt     = BIT_RELOAD;
        w_shift_nxt    = w_tx_byte;
      end
      TX_START: if (w_bit_end) begin
        w_tx_state_nxt = TX_DATA;
        w_baud_nxt     = BIT_RELOAD;
        w_bit_idx_nxt  = 3'd0;
      end
      TX_DATA: if (w_bit_end) begin
        w_baud_nxt = BIT_RELOAD;
        if (r_bit_idx == 3'd7) begin
          w_tx_state_nxt = TX_STOP;
        end else begin
          w_bit_idx_nxt = r_bit_idx + 3'd1;
          w_shift_nxt   = {1'b0, r_shift[7:1]};
        end
      end
      TX_STOP: if (w_bit_end) begin
        if (w_tx_start) begin
          w_tx_state_nxt = TX_START;
          w_baud_nxt     = BIT_RELOAD;
          w_shift_nxt    = w_tx_byte;
        end else begin
          w_tx_state_nxt = TX_IDLE;
        end
      end
      default: w_tx_state_nxt = TX_IDLE;
    endcase
    w_line_nxt = (w_tx_state_nxt == TX_START) ? 1'b0 :
                 (w_tx_state_nxt == TX_DATA)  ? w_shift_nxt[0] : 1'b1;
  end

  always_ff @(posedge sysclk_50 or negedge i_rest_n) begin
    if (!i_rest_n) begin
      r_tx_state <= TX_IDLE;
      r_baud_cnt <= '0;
      r_bit_idx  <= 3'd0;
      r_shift    <= 8'd0;
      r_line     <= 1'b1;
    end else begin
      r_tx_state <= w_tx_state_nxt;
      r_baud_cnt <= w_baud_nxt;
      r_bit_idx  <= w_bit_idx_nxt;
      r_shift    <= w_shift_nxt;
      r_line     <= w_line_nxt;
    end
  end

  // The next sample is fetched while the previous byte is still on the line.
  always_comb begin
    w_state_nxt  = r_state;
    w_idx_nxt    = r_idx;
    w_sample_nxt = r_sample;
    w_tail_nxt   = r_tail;
    w_cnt_nxt    = r_frame_cnt;
    w_tx_start   = 1'b0;
    w_tx_byte    = HEADER;
`ifdef ADC_FRAMER_CHECKSUM_EN
    w_cksum_nxt  = r_cksum;
`endif
    case (r_state)
      IDLE: if (enable && !fifo_empty) begin
        w_state_nxt = HDR;
        w_idx_nxt   = 8'd0;
        w_tail_nxt  = 1'b0;
`ifdef ADC_FRAMER_CHECKSUM_EN
        w_cksum_nxt = 8'd0;
`endif
      end
      HDR: begin
        w_tx_start  = 1'b1;
        w_state_nxt = FETCH;
      end
      FETCH: if (!fifo_empty) w_state_nxt = WAIT_Q;
      WAIT_Q: begin
        w_sample_nxt = fifo_q;
        w_state_nxt  = SEND_HI;
      end
      SEND_HI: if (w_tx_ready) begin
        w_tx_start  = 1'b1;
        w_tx_byte   = r_sample[15:8];
`ifdef ADC_FRAMER_CHECKSUM_EN
        w_cksum_nxt = r_cksum + r_sample[15:8];
`endif
        w_state_nxt = SEND_LO;
      end
      SEND_LO: begin
        if (r_tail) begin
          if (w_tx_done) w_state_nxt = DONE;
        end else if (w_tx_ready) begin
          w_tx_start  = 1'b1;
          w_tx_byte   = r_sample[7:0];
`ifdef ADC_FRAMER_CHECKSUM_EN
          w_cksum_nxt = r_cksum + r_sample[7:0];
`endif
          if (r_idx == LAST_IDX) begin
`ifdef ADC_FRAMER_CHECKSUM_EN
            w_state_nxt = CKSUM;
`else
            w_tail_nxt  = 1'b1;
`endif
          end else begin
            w_idx_nxt   = r_idx + 8'd1;
            w_state_nxt = FETCH;
          end
        end
      end
`ifdef ADC_FRAMER_CHECKSUM_EN
      CKSUM: begin
        if (r_tail) begin
          if (w_tx_done) w_state_nxt = DONE;
        end else if (w_tx_ready) begin
          w_tx_start = 1'b1;
          w_tx_byte  = r_cksum;
          w_tail_nxt = 1'b1;
        end
      end
`endif
      DONE: begin
        w_cnt_nxt   = r_frame_cnt + 16'd1;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge sysclk_50 or negedge i_rest_n) begin
    if (!i_rest_n) begin
      r_state     <= IDLE;
      r_idx       <= 8'd0;
      r_sample    <= 16'd0;
      r_tail      <= 1'b0;
      r_frame_cnt <= 16'd0;
`ifdef ADC_FRAMER_CHECKSUM_EN
      r_cksum     <= 8'd0;
`endif
    end else begin
      r_state     <= w_state_nxt;
      r_idx       <= w_idx_nxt;
      r_sample    <= w_sample_nxt;
      r_tail      <= w_tail_nxt;
      r_frame_cnt <= w_cnt_nxt;
`ifdef ADC_FRAMER_CHECKSUM_EN
      r_cksum     <= w_cksum_nxt;
`endif
    end
  end

  assign fifo_rdreq = (r_state == FETCH) && !fifo_empty;
  assign busy       = (r_state != IDLE) && (r_state != DONE);
  assign frame_done = (r_state == DONE);
  assign frame_cnt  = r_frame_cnt;
  assign uart_tx    = r_line;
endmodule
